// File: rtl/nfc_pkg.sv
// Shared constants for the NAND flash controller command path: ACG field widths,
// ACG command bit positions, idle values, host opcodes and the dispatcher state type.
package nfc_pkg;
    localparam int AcgCommandWidth   = 8;
    localparam int AcgOptionWidth    = 3;
    localparam int AcgNumOfDataWidth = 16;
    localparam int AcgCADataWidth    = 40;

    // Bit positions inside the one-hot ACG command byte
    localparam int AcgBitDataIn  = 1;
    localparam int AcgBitCmdAddr = 3;
    localparam int AcgBitDataOut = 5;
    localparam int AcgBitReset   = 6;

    localparam logic [AcgCommandWidth-1:0]   AcgIdleCommand   = 8'h00;
    localparam logic [AcgOptionWidth-1:0]    AcgIdleOption    = 3'b000;
    localparam logic [AcgNumOfDataWidth-1:0] AcgIdleNumOfData = 16'h0000;
    localparam logic                         AcgIdleCASelect  = 1'b1;
    localparam logic [AcgCADataWidth-1:0]    AcgIdleCAData    = 40'h0;

    // Host opcodes, one per attached command module
    localparam logic [5:0] OpReset       = 6'b000001;
    localparam logic [5:0] OpGetFeature  = 6'b000010;
    localparam logic [5:0] OpSetFeature  = 6'b000011;
    localparam logic [5:0] OpReadPage    = 6'b000100;
    localparam logic [5:0] OpProgramPage = 6'b000101;

    typedef enum logic {
        StateIdle  = 1'b0,
        StateOwned = 1'b1
    } dispatchState_t;
endpackage

// File: rtl/nfc_acg_dispatcher_if.sv
// ACG request bus driven by the dispatcher (master) toward the ACG bank (slave).
interface nfc_acg_dispatcher_if
    import nfc_pkg::*;
#(
    parameter int NumberOfWays = 4
);
    logic [AcgCommandWidth-1:0]   oACG_Command;
    logic [AcgOptionWidth-1:0]    oACG_CommandOption;
    logic [NumberOfWays-1:0]      oACG_TargetWay;
    logic [AcgNumOfDataWidth-1:0] oACG_NumOfData;
    logic                         oACG_CASelect;
    logic [AcgCADataWidth-1:0]    oACG_CAData;

    modport master (
        output oACG_Command, oACG_CommandOption, oACG_TargetWay,
               oACG_NumOfData, oACG_CASelect, oACG_CAData
    );
    modport slave (
        input  oACG_Command, oACG_CommandOption, oACG_TargetWay,
               oACG_NumOfData, oACG_CASelect, oACG_CAData
    );
endinterface

// File: rtl/nfc_acg_slice_mux.sv
// Selects one module's slice of a flattened per-module field; drives iIdle when disabled.
module nfc_acg_slice_mux #(
    parameter int NumberOfCommands = 4,
    parameter int Width            = 8,
    parameter int OwnerWidth       = 2
) (
    input  logic [NumberOfCommands*Width-1:0] iSlices,
    input  logic [OwnerWidth-1:0]             iSelect,
    input  logic                              iEnable,
    input  logic [Width-1:0]                  iIdle,
    output logic [Width-1:0]                  oData
);
    always_comb begin
        oData = iIdle;
        if (iEnable) begin
            for (int i = 0; i < NumberOfCommands; i++) begin
                if (iSelect == OwnerWidth'(i)) oData = iSlices[i*Width +: Width];
            end
        end
    end
endmodule

// File: rtl/nfc_acg_dispatcher.sv
// Arbitrates the single ACG bus among command modules: one owner at a time, lowest start wins.
// Optional busy watchdog: define NFC_ACG_DISPATCH_WATCHDOG_EN.
module nfc_acg_dispatcher
    import nfc_pkg::*;
#(
    parameter int NumberOfCommands = 4,
    parameter int NumberOfWays     = 4,
    parameter int OwnerWidth       = 2,
    parameter int WatchdogCycles   = 65535
) (
    input  logic                                          iSystemClock,
    input  logic                                          iReset,
    input  logic                                          iCMDValid,
    output logic                                          oCMDReady,
    output logic                                          oCmd_CMDValid,
    input  logic [NumberOfCommands-1:0]                   iCmd_CMDReady,
    input  logic [NumberOfCommands-1:0]                   iCmd_Start,
    input  logic [NumberOfCommands-1:0]                   iCmd_LastStep,
    input  logic [NumberOfCommands*AcgCommandWidth-1:0]   iCmd_ACG_Command,
    input  logic [NumberOfCommands*AcgOptionWidth-1:0]    iCmd_ACG_CommandOption,
    input  logic [NumberOfCommands*NumberOfWays-1:0]      iCmd_ACG_TargetWay,
    input  logic [NumberOfCommands*AcgNumOfDataWidth-1:0] iCmd_ACG_NumOfData,
    input  logic [NumberOfCommands-1:0]                   iCmd_ACG_CASelect,
    input  logic [NumberOfCommands*AcgCADataWidth-1:0]    iCmd_ACG_CAData,
    nfc_acg_dispatcher_if.master                          acg,
    output logic                                          oBusy,
    output logic [OwnerWidth-1:0]                         oOwner,
    output logic                                          oLastStep,
    output logic                                          oError,
    output logic                                          oTimeout
);
    dispatchState_t          rState;
    logic                    rBusy;
    logic [OwnerWidth-1:0]   rOwner;
    logic                    rError;
    logic [OwnerWidth-1:0]   startIdx;
    logic                    multiStart;
    logic                    ownerLast;

    assign rBusy = (rState == StateOwned);

    always_comb begin
        startIdx = '0;
        for (int i = NumberOfCommands - 1; i >= 0; i--) begin
            if (iCmd_Start[i]) startIdx = OwnerWidth'(i);
        end
    end
    // More than one bit set iff clearing the lowest set bit leaves something
    assign multiStart = |(iCmd_Start & (iCmd_Start - NumberOfCommands'(1)));

`ifdef NFC_ACG_DISPATCH_WATCHDOG_EN
    logic [31:0] rWdCount;
    logic        rTimeout;
    logic        wdHit;
    // Compare the incremented count so ownership lasts exactly WatchdogCycles cycles
    assign wdHit = ((rWdCount + 32'd1) == 32'(WatchdogCycles));
`endif

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            rState <= StateIdle;
            rOwner <= '0;
            rError <= 1'b0;
`ifdef NFC_ACG_DISPATCH_WATCHDOG_EN
            rWdCount <= '0;
            rTimeout <= 1'b0;
`endif
        end else begin
            case (rState)
                StateIdle: begin
                    if (|iCmd_Start) begin
                        rState <= StateOwned;
                        rOwner <= startIdx;
                        if (multiStart) rError <= 1'b1;
                    end
`ifdef NFC_ACG_DISPATCH_WATCHDOG_EN
                    rWdCount <= '0;
`endif
                end
                StateOwned: begin
                    if (|iCmd_Start) rError <= 1'b1;
                    if (ownerLast) rState <= StateIdle;
`ifdef NFC_ACG_DISPATCH_WATCHDOG_EN
                    else if (wdHit) begin
                        rState   <= StateIdle;
                        rTimeout <= 1'b1;
                    end
                    rWdCount <= rWdCount + 32'd1;
`endif
                end
                default: rState <= StateIdle;
            endcase
        end
    end

`ifdef NFC_ACG_DISPATCH_WATCHDOG_EN
    assign oTimeout = rTimeout;
`else
    assign oTimeout = 1'b0;
`endif

    assign oCMDReady     = ~rBusy & (&iCmd_CMDReady);
    assign oCmd_CMDValid = iCMDValid & oCMDReady;
    assign oBusy         = rBusy;
    assign oOwner        = rOwner;
    assign oError        = rError;
    assign oLastStep     = ownerLast;

    nfc_acg_slice_mux #(.NumberOfCommands(NumberOfCommands), .Width(1), .OwnerWidth(OwnerWidth))
        uLastMux (.iSlices(iCmd_LastStep), .iSelect(rOwner), .iEnable(rBusy),
                  .iIdle(1'b0), .oData(ownerLast));
    nfc_acg_slice_mux #(.NumberOfCommands(NumberOfCommands), .Width(AcgCommandWidth), .OwnerWidth(OwnerWidth))
        uCmdMux (.iSlices(iCmd_ACG_Command), .iSelect(rOwner), .iEnable(rBusy),
                 .iIdle(AcgIdleCommand), .oData(acg.oACG_Command));
    nfc_acg_slice_mux #(.NumberOfCommands(NumberOfCommands), .Width(AcgOptionWidth), .OwnerWidth(OwnerWidth))
        uOptMux (.iSlices(iCmd_ACG_CommandOption), .iSelect(rOwner), .iEnable(rBusy),
                 .iIdle(AcgIdleOption), .oData(acg.oACG_CommandOption));
    nfc_acg_slice_mux #(.NumberOfCommands(NumberOfCommands), .Width(NumberOfWays), .OwnerWidth(OwnerWidth))
        uWayMux (.iSlices(iCmd_ACG_TargetWay), .iSelect(rOwner), .iEnable(rBusy),
                 .iIdle({NumberOfWays{1'b1}}), .oData(acg.oACG_TargetWay));
    nfc_acg_slice_mux #(.NumberOfCommands(NumberOfCommands), .Width(AcgNumOfDataWidth), .OwnerWidth(OwnerWidth))
        uNumMux (.iSlices(iCmd_ACG_NumOfData), .iSelect(rOwner), .iEnable(rBusy),
                 .iIdle(AcgIdleNumOfData), .oData(acg.oACG_NumOfData));
    nfc_acg_slice_mux #(.NumberOfCommands(NumberOfCommands), .Width(1), .OwnerWidth(OwnerWidth))
        uCasMux (.iSlices(iCmd_ACG_CASelect), .iSelect(rOwner), .iEnable(rBusy),
                 .iIdle(AcgIdleCASelect), .oData(acg.oACG_CASelect));
    nfc_acg_slice_mux #(.NumberOfCommands(NumberOfCommands), .Width(AcgCADataWidth), .OwnerWidth(OwnerWidth))
        uCadMux (.iSlices(iCmd_ACG_CAData), .iSelect(rOwner), .iEnable(rBusy),
                 .iIdle(AcgIdleCAData), .oData(acg.oACG_CAData));
endmodule
